alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Registered issue stage between instruction decode and the ALU in the RISC-V datapath. Decodes R-type and I-type integer ALU instructions into the 5-bit ALU function code and the two 32-bit operands the ALU consumes. Holds them in a single-entry pipeline register behind a valid/ready handshake, with stall and flush support. It is the producer side of the ALU's `x`/`y`/`ALUFn` interface.

## Interface
- `XLEN`, 32: operand width; only 32 is supported.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard the held entry and drop the incoming one this cycle.
- `in_valid` in 1: upstream offers `instr`, `rs1_val`, `rs2_val`.
- `in_ready` out 1: stage accepts this cycle.
- `instr` in 32: raw instruction word.
- `rs1_val` in 32: register-file value of rs1.
- `rs2_val` in 32: register-file value of rs2.
- `out_valid` out 1: registered entry present.
- `out_ready` in 1: ALU/EX side consumes this cycle.
- `alu_x` out 32: ALU operand x.
- `alu_y` out 32: ALU operand y.
- `alu_fn` out 5: ALU function code.
- `rd` out 5: destination register, `instr[11:7]`.
- `illegal` out 1: decoded entry is unsupported.
- `illegal_cnt` out 16: saturating count of illegal entries issued.

## Operation
- Function codes:
  - ADD = 5'b00010, SUB = 5'b00110, AND = 5'b00000, OR = 5'b00001, XOR = 5'b00011, SLL = 5'b00100, SRL = 5'b01000.
- R-type (opcode 7'b0110011), decoded by funct7/funct3:
  - 0000000/000 → ADD; 0100000/000 → SUB; 0000000/111 → AND; 0000000/110 → OR; 0000000/100 → XOR; 0000000/001 → SLL; 0000000/101 → SRL.
  - `alu_x = rs1_val`, `alu_y = rs2_val`.
- I-type (opcode 7'b0010011), decoded by funct3:
  - 000 ADDI → ADD; 111 → AND; 110 → OR; 100 → XOR.
  - For these, `alu_y` = `instr[31:20]` sign-extended to 32 bits.
  - SLLI (001) and SRLI (101) require `instr[31:25]` = 0; `alu_y` = `{27'b0, instr[24:20]}`.
  - `alu_x = rs1_val`.
- Any other opcode/funct combination, including SLT, SLTU, SRA and SUB-immediate forms:
  - `illegal` = 1, `alu_fn` = ADD, `alu_x` = `alu_y` = 0, `rd` = 0. The entry is still issued so the pipeline keeps order.
- Handshake:
  - `in_ready = !out_valid || out_ready` (combinational).
  - A transfer into the stage occurs when `in_valid && in_ready && !flush`.
  - A transfer out occurs when `out_valid && out_ready`.
  - Simultaneous in and out transfers replace the entry with no bubble.
- While `out_valid` is high and `out_ready` is low, all outputs hold stable.
- `flush` has priority over every handshake: next cycle `out_valid` = 0, and the incoming instruction is dropped even if `in_valid && in_ready`.
- `illegal_cnt` increments on each output transfer with `illegal` = 1, saturates at 16'hFFFF, and is not cleared by `flush`.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N with `out_valid` = 1.
- Throughput is 1 instruction per cycle when `out_ready` is held high.
- Reset values: `out_valid` 0, `alu_x` 0, `alu_y` 0, `alu_fn` ADD (5'b00010), `rd` 0, `illegal` 0, `illegal_cnt` 0. `in_ready` reads 1 during and after reset.
- `rst` asserted mid-stall drops the held entry; there is no partial state.
- `rst` has priority over `flush`.
- Payload registers load only on an input transfer. When `out_valid` = 0 they hold their last value (don't-care).

## Structure
- Shared package `alu_pkg`:
  - ALU function-code constants (ALU_ADD … ALU_SRL).
  - Opcode constants OP_REG = 7'b0110011 and OP_IMM = 7'b0010011.
  - funct3 constants.
- Natural sub-module `alu_fn_decode`: purely combinational, mapping instr → {alu_fn, imm_sel, imm, illegal}. The top level holds the handshake, payload register and counter.

## Test plan
- Reset, then `add x1,x2,x3` (instr 32'h003100B3, rs1=5, rs2=7) with `out_ready`=1 → next cycle: `out_valid`=1, `alu_fn`=5'b00010, `alu_x`=5, `alu_y`=7, `rd`=1, `illegal`=0.
- `sub x5,x6,x7` (32'h407302B3), then `addi x1,x0,-1` (32'hFFF00093) back-to-back → consecutive cycles show:
  - first: `alu_fn`=5'b00110;
  - second: `alu_fn`=5'b00010, `alu_y`=32'hFFFFFFFF;
  - no bubble between them.
- Stall: hold `out_ready`=0 for 3 cycles with a new `in_valid` → `in_ready`=0, outputs unchanged for 3 cycles. The new entry is accepted on the cycle `out_ready` rises.
- Illegal: SRA (funct7 0100000, funct3 101, opcode 0110011) → `illegal`=1, `alu_fn`=ADD, `alu_x`=`alu_y`=0. `illegal_cnt` goes 0→1 on consume.
- Flush during stall with `in_valid`=1 → next cycle `out_valid`=0, the incoming instruction is not issued, `illegal_cnt` is unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue stage: function codes,
// opcodes, funct fields and the operand-y source select.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_XOR = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SRL = 5'b01000;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Where operand y comes from: the rs2 register value or the decoded immediate
    typedef enum logic {
        SEL_RS2 = 1'b0,
        SEL_IMM = 1'b1
    } ysel_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundles the decode-side and ALU-side handshakes of the issue stage.
// The stage itself uses the slave view; whoever drives instructions in and
// consumes operands out uses the master view.
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_x;
    logic [XLEN-1:0] alu_y;
    logic [4:0]      alu_fn;
    logic [4:0]      rd;
    logic            illegal;
    logic [15:0]     illegal_cnt;

    modport slave (
        input  in_valid, instr, rs1_val, rs2_val, out_ready,
        output in_ready, out_valid, alu_x, alu_y, alu_fn, rd, illegal, illegal_cnt
    );

    modport master (
        output in_valid, instr, rs1_val, rs2_val, out_ready,
        input  in_ready, out_valid, alu_x, alu_y, alu_fn, rd, illegal, illegal_cnt
    );

endinterface

// File: rtl/alu_fn_decode.sv
// Combinational decoder: maps an R-type or I-type integer ALU instruction
// to its ALU function code, operand-y source and immediate. Anything the
// ALU cannot execute is flagged illegal and reported as a harmless ADD.
module alu_fn_decode
    import alu_pkg::*;
(
    input  logic [31:0]     instr_i,
    output logic [4:0]      alu_fn_o,
    output ysel_e           imm_sel_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unusedBits;

    assign opcode     = instr_i[6:0];
    assign funct3     = instr_i[14:12];
    assign funct7     = instr_i[31:25];
    assign unusedBits = ^{instr_i[19:15], instr_i[11:7]};

    // Select the function code and y source from opcode/funct fields
    always_comb begin
        alu_fn_o  = ALU_ADD;
        imm_sel_o = SEL_RS2;
        imm_o     = '0;
        illegal_o = 1'b0;
        case (opcode)
            OP_REG: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  alu_fn_o = ALU_ADD;
                        F3_AND:  alu_fn_o = ALU_AND;
                        F3_OR:   alu_fn_o = ALU_OR;
                        F3_XOR:  alu_fn_o = ALU_XOR;
                        F3_SLL:  alu_fn_o = ALU_SLL;
                        F3_SRL:  alu_fn_o = ALU_SRL;
                        default: illegal_o = 1'b1;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    alu_fn_o = ALU_SUB;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_IMM: begin
                imm_sel_o = SEL_IMM;
                case (funct3)
                    F3_ADD, F3_AND, F3_OR, F3_XOR: begin
                        imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
                        case (funct3)
                            F3_AND:  alu_fn_o = ALU_AND;
                            F3_OR:   alu_fn_o = ALU_OR;
                            F3_XOR:  alu_fn_o = ALU_XOR;
                            default: alu_fn_o = ALU_ADD;
                        endcase
                    end
                    F3_SLL, F3_SRL: begin
                        imm_o     = {27'b0, instr_i[24:20]};
                        alu_fn_o  = (funct3 == F3_SLL) ? ALU_SLL : ALU_SRL;
                        illegal_o = (funct7 != F7_BASE);
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
        if (illegal_o) begin
            alu_fn_o  = ALU_ADD;
            imm_sel_o = SEL_RS2;
            imm_o     = '0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Single-entry registered issue stage between decode and the ALU. Decodes
// the incoming instruction, captures the ALU operands behind a valid/ready
// handshake, and counts illegal entries handed to the ALU.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    alu_issue_stage_if.slave bus
);

    logic [4:0]      decFn;
    ysel_e           decSel;
    logic [XLEN-1:0] decImm;
    logic            decIll;

    logic            outValid_q, outValid_d;
    logic [XLEN-1:0] aluX_q, aluX_d;
    logic [XLEN-1:0] aluY_q, aluY_d;
    logic [4:0]      aluFn_q, aluFn_d;
    logic [4:0]      rd_q, rd_d;
    logic            illegal_q, illegal_d;
    logic [15:0]     illCnt_q, illCnt_d;

    logic inXfer;
    logic outXfer;

    alu_fn_decode u_decode (
        .instr_i   (bus.instr),
        .alu_fn_o  (decFn),
        .imm_sel_o (decSel),
        .imm_o     (decImm),
        .illegal_o (decIll)
    );

    assign bus.in_ready = !outValid_q || bus.out_ready;
    assign inXfer       = bus.in_valid && bus.in_ready && !flush;
    assign outXfer      = outValid_q && bus.out_ready;

    // Next-state: flush empties the stage; otherwise load, drain or hold
    always_comb begin
        outValid_d = outValid_q;
        aluX_d     = aluX_q;
        aluY_d     = aluY_q;
        aluFn_d    = aluFn_q;
        rd_d       = rd_q;
        illegal_d  = illegal_q;
        illCnt_d   = illCnt_q;
        if (flush) begin
            outValid_d = 1'b0;
        end else begin
            if (outXfer && illegal_q && illCnt_q != 16'hFFFF) begin
                illCnt_d = illCnt_q + 16'd1;
            end
            if (inXfer) begin
                outValid_d = 1'b1;
                aluFn_d    = decFn;
                illegal_d  = decIll;
                aluX_d     = decIll ? '0 : bus.rs1_val;
                aluY_d     = decIll ? '0 : ((decSel == SEL_IMM) ? decImm : bus.rs2_val);
                rd_d       = decIll ? 5'd0 : bus.instr[11:7];
            end else if (outXfer) begin
                outValid_d = 1'b0;
            end
        end
    end

    // Pipeline register with synchronous reset taking priority over flush
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            aluX_q     <= '0;
            aluY_q     <= '0;
            aluFn_q    <= ALU_ADD;
            rd_q       <= 5'd0;
            illegal_q  <= 1'b0;
            illCnt_q   <= 16'd0;
        end else begin
            outValid_q <= outValid_d;
            aluX_q     <= aluX_d;
            aluY_q     <= aluY_d;
            aluFn_q    <= aluFn_d;
            rd_q       <= rd_d;
            illegal_q  <= illegal_d;
            illCnt_q   <= illCnt_d;
        end
    end

    assign bus.out_valid   = outValid_q;
    assign bus.alu_x       = aluX_q;
    assign bus.alu_y       = aluY_q;
    assign bus.alu_fn      = aluFn_q;
    assign bus.rd          = rd_q;
    assign bus.illegal     = illegal_q;
    assign bus.illegal_cnt = illCnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed instruction vectors, an
// instruction-level reference model checked every cycle, and hand-computed
// expectations at the key points of each scenario.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [4:0]  fn;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  rd;
        logic        ill;
    } entry_t;

    localparam logic [31:0] I_ADD  = 32'h003100B3;
    localparam logic [31:0] I_SUB  = 32'h407302B3;
    localparam logic [31:0] I_ADDI = 32'hFFF00093;
    localparam logic [31:0] I_XOR  = 32'h0020C233;
    localparam logic [31:0] I_ANDI = 32'h0F03F313;
    localparam logic [31:0] I_SRA  = 32'h4020D1B3;
    localparam logic [31:0] I_SLT  = 32'h0020A1B3;
    localparam logic [31:0] I_SRLI = 32'h0041D113;
    localparam logic [31:0] I_SRAI = 32'h4041D113;

    logic clk;
    logic rst;
    logic flush;
    int   checks;
    int   errors;

    logic        mKnown;
    logic        mValid;
    logic [15:0] mCnt;
    entry_t      mEntry;

    alu_issue_stage_if bus ();

    alu_issue_stage dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // What the ALU must receive for one instruction, from the ISA rules
    function automatic entry_t refDecode(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        logic [6:0]  op    = ins[6:0];
        logic [2:0]  f3    = ins[14:12];
        logic [6:0]  f7    = ins[31:25];
        logic [31:0] immS  = {{20{ins[31]}}, ins[31:20]};
        logic [31:0] shamt = {27'd0, ins[24:20]};
        logic        legal = 1'b1;
        logic [4:0]  fn    = 5'd2;
        logic [31:0] y     = 32'd0;
        entry_t      e;
        if (op == 7'h33 && f7 == 7'h00) begin
            y = r2;
            case (f3)
                3'd0: fn = 5'd2;
                3'd7: fn = 5'd0;
                3'd6: fn = 5'd1;
                3'd4: fn = 5'd3;
                3'd1: fn = 5'd4;
                3'd5: fn = 5'd8;
                default: legal = 1'b0;
            endcase
        end else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
            fn = 5'd6;
            y  = r2;
        end else if (op == 7'h13) begin
            case (f3)
                3'd0: begin fn = 5'd2; y = immS; end
                3'd7: begin fn = 5'd0; y = immS; end
                3'd6: begin fn = 5'd1; y = immS; end
                3'd4: begin fn = 5'd3; y = immS; end
                3'd1: begin fn = 5'd4; y = shamt; legal = (f7 == 7'h00); end
                3'd5: begin fn = 5'd8; y = shamt; legal = (f7 == 7'h00); end
                default: legal = 1'b0;
            endcase
        end else begin
            legal = 1'b0;
        end
        if (legal) e = '{fn: fn, x: r1, y: y, rd: ins[11:7], ill: 1'b0};
        else       e = '{fn: 5'd2, x: 32'd0, y: 32'd0, rd: 5'd0, ill: 1'b1};
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] ins, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic outReady, input logic fl, input logic rs);
        bus.in_valid  = valid;
        bus.instr     = ins;
        bus.rs1_val   = r1;
        bus.rs2_val   = r2;
        bus.out_ready = outReady;
        flush         = fl;
        rst           = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic checkEntry(input string name, input logic [4:0] fn, input logic [31:0] x,
                              input logic [31:0] y, input logic [4:0] rd, input logic ill);
        checkOutput({name, "_valid"}, bus.out_valid, 1);
        checkOutput({name, "_fn"}, bus.alu_fn, fn);
        checkOutput({name, "_x"}, bus.alu_x, x);
        checkOutput({name, "_y"}, bus.alu_y, y);
        checkOutput({name, "_rd"}, bus.rd, rd);
        checkOutput({name, "_ill"}, bus.illegal, ill);
    endtask

    // Reference model: occupancy, held entry and illegal count per clock
    always @(posedge clk) begin
        if (rst) begin
            mKnown <= 1'b1;
            mValid <= 1'b0;
            mCnt   <= 16'd0;
        end else if (flush) begin
            mValid <= 1'b0;
        end else begin
            if (mValid && bus.out_ready && mEntry.ill && mCnt != 16'hFFFF) mCnt <= mCnt + 16'd1;
            if (bus.in_valid && (!mValid || bus.out_ready)) begin
                mValid <= 1'b1;
                mEntry <= refDecode(bus.instr, bus.rs1_val, bus.rs2_val);
            end else if (mValid && bus.out_ready) begin
                mValid <= 1'b0;
            end
        end
    end

    // Compare the DUT with the model midway through every cycle
    initial begin
        forever begin
            @(negedge clk);
            if (mKnown === 1'b1) begin
                checkOutput("cmp_out_valid", bus.out_valid, mValid);
                checkOutput("cmp_in_ready", bus.in_ready, !mValid || bus.out_ready);
                checkOutput("cmp_illegal_cnt", bus.illegal_cnt, mCnt);
                if (mValid) begin
                    checkOutput("cmp_alu_fn", bus.alu_fn, mEntry.fn);
                    checkOutput("cmp_alu_x", bus.alu_x, mEntry.x);
                    checkOutput("cmp_alu_y", bus.alu_y, mEntry.y);
                    checkOutput("cmp_rd", bus.rd, mEntry.rd);
                    checkOutput("cmp_illegal", bus.illegal, mEntry.ill);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        mKnown = 1'b0;
        mValid = 1'b0;
        mCnt   = 16'd0;
        mEntry = '0;

        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("rst_in_ready", bus.in_ready, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_alu_fn", bus.alu_fn, 5'b00010);
        checkOutput("rst_alu_x", bus.alu_x, 0);
        checkOutput("rst_alu_y", bus.alu_y, 0);
        checkOutput("rst_rd", bus.rd, 0);
        checkOutput("rst_illegal", bus.illegal, 0);
        checkOutput("rst_cnt", bus.illegal_cnt, 0);
        checkOutput("rst_in_ready_after", bus.in_ready, 1);

        applyStimulus(1, I_ADD, 5, 7, 1, 0, 0);
        checkEntry("add", 5'b00010, 5, 7, 1, 0);

        applyStimulus(1, I_SUB, 10, 3, 1, 0, 0);
        checkEntry("sub", 5'b00110, 10, 3, 5, 0);
        applyStimulus(1, I_ADDI, 0, 99, 1, 0, 0);
        checkEntry("addi", 5'b00010, 0, 32'hFFFFFFFF, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("drain_valid", bus.out_valid, 0);

        applyStimulus(1, I_XOR, 32'hF0F0, 32'h0FF0, 1, 0, 0);
        checkEntry("xor", 5'b00011, 32'hF0F0, 32'h0FF0, 4, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, I_ANDI, 7, 0, 0, 0, 0);
            checkEntry("stall", 5'b00011, 32'hF0F0, 32'h0FF0, 4, 0);
            checkOutput("stall_in_ready", bus.in_ready, 0);
        end
        applyStimulus(1, I_ANDI, 7, 0, 1, 0, 0);
        checkEntry("andi", 5'b00000, 7, 32'h0F0, 6, 0);

        applyStimulus(1, I_SRA, 9, 9, 1, 0, 0);
        checkEntry("sra", 5'b00010, 0, 0, 0, 1);
        checkOutput("sra_cnt_before", bus.illegal_cnt, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("sra_cnt_after", bus.illegal_cnt, 1);
        checkOutput("sra_drained", bus.out_valid, 0);

        applyStimulus(1, I_SLT, 4, 4, 1, 0, 0);
        checkEntry("slt", 5'b00010, 0, 0, 0, 1);
        applyStimulus(1, I_ADD, 1, 1, 0, 0, 0);
        checkOutput("slt_stall_in_ready", bus.in_ready, 0);
        applyStimulus(1, I_ADD, 1, 1, 0, 1, 0);
        checkOutput("flush_valid", bus.out_valid, 0);
        checkOutput("flush_cnt", bus.illegal_cnt, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("flush_dropped", bus.out_valid, 0);
        applyStimulus(1, I_ADD, 2, 2, 1, 1, 0);
        checkOutput("flush_empty_drop", bus.out_valid, 0);
        checkOutput("flush_cnt_kept", bus.illegal_cnt, 1);

        applyStimulus(1, I_SRLI, 32'h80, 0, 1, 0, 0);
        checkEntry("srli", 5'b01000, 32'h80, 4, 2, 0);
        applyStimulus(1, I_SRAI, 32'h80, 0, 1, 0, 0);
        checkEntry("srai", 5'b00010, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("srai_cnt", bus.illegal_cnt, 2);

        applyStimulus(1, I_ADD, 3, 4, 0, 0, 0);
        checkEntry("pre_rst", 5'b00010, 3, 4, 1, 0);
        applyStimulus(1, I_SUB, 3, 4, 0, 0, 1);
        checkOutput("midrst_valid", bus.out_valid, 0);
        checkOutput("midrst_cnt", bus.illegal_cnt, 0);
        checkOutput("midrst_in_ready", bus.in_ready, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
